// File: rtl/mul4_vector_divider_if.sv
// Handshake and bit-plane bus for the bit-sliced 4-bit / 2-bit vector divider.
// The master drives operands and result acceptance; the divider is the slave.
interface mul4_vector_divider_if #(
    parameter int LANES = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [LANES-1:0] y3, y2, y1, y0;
    logic [LANES-1:0] b1, b0;
    logic             out_valid;
    logic             out_ready;
    logic [LANES-1:0] q3, q2, q1, q0;
    logic [LANES-1:0] r1, r0;
    logic [LANES-1:0] exact;
    logic [LANES-1:0] dz;

    modport master (
        output in_valid, y3, y2, y1, y0, b1, b0, out_ready,
        input  in_ready, out_valid, q3, q2, q1, q0, r1, r0, exact, dz
    );

    modport slave (
        input  in_valid, y3, y2, y1, y0, b1, b0, out_ready,
        output in_ready, out_valid, q3, q2, q1, q0, r1, r0, exact, dz
    );
endinterface

// File: rtl/mul4_vector_divider.sv
// Bit-sliced restoring divider: LANES lanes of 4-bit dividend / 2-bit divisor,
// all lanes stepping one quotient bit per clock through a shared 4-iteration loop.
module mul4_vector_divider #(
    parameter int LANES = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    mul4_vector_divider_if.slave        bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [1:0]             iter_q;
    logic [LANES-1:0][3:0]  dvd_q;
    logic [LANES-1:0][1:0]  dvs_q;
    logic [LANES-1:0][1:0]  rem_q, rem_nxt;
    logic [LANES-1:0][3:0]  quo_q, quo_nxt;

    logic [LANES-1:0][3:0]  q_q;
    logic [LANES-1:0][1:0]  r_q;
    logic [LANES-1:0]       exact_q;
    logic [LANES-1:0]       dz_q;

    wire accept   = (state_q == IDLE) && bus.in_valid;
    wire last_it  = (state_q == BUSY) && (iter_q == 2'd0);

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: state_d gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.in_valid)  state_d = BUSY;
            BUSY:    if (iter_q == 2'd0) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // One restoring step per lane. Zero-divisor lanes skip the compare; their
    // quotient and remainder are forced when the result is registered.
    always_comb begin
        rem_nxt = rem_q;
        quo_nxt = quo_q;
        for (int k = 0; k < LANES; k++) begin
            logic [2:0] sh;
            logic [2:0] df;
            sh = {rem_q[k], dvd_q[k][iter_q]};
            df = sh - {1'b0, dvs_q[k]};
            if (dvs_q[k] == 2'd0) begin
                rem_nxt[k]         = 2'd0;
                quo_nxt[k][iter_q] = 1'b1;
            end else if (sh >= {1'b0, dvs_q[k]}) begin
                rem_nxt[k]         = df[1:0];
                quo_nxt[k][iter_q] = 1'b1;
            end else begin
                rem_nxt[k]         = sh[1:0];
                quo_nxt[k][iter_q] = 1'b0;
            end
        end
    end

    // NOTE: every datapath and result register is reset, so an aborted
    // operation leaves no stale quotient visible after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iter_q  <= 2'd0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            exact_q <= '0;
            dz_q    <= '0;
        end else if (accept) begin
            iter_q <= 2'd3;
            rem_q  <= '0;
            quo_q  <= '0;
            for (int k = 0; k < LANES; k++) begin
                dvd_q[k] <= {bus.y3[k], bus.y2[k], bus.y1[k], bus.y0[k]};
                dvs_q[k] <= {bus.b1[k], bus.b0[k]};
            end
        end else if (state_q == BUSY) begin
            iter_q <= iter_q - 2'd1;
            rem_q  <= rem_nxt;
            quo_q  <= quo_nxt;
            if (last_it) begin
                for (int k = 0; k < LANES; k++) begin
                    if (dvs_q[k] == 2'd0) begin
                        q_q[k]     <= 4'hF;
                        r_q[k]     <= dvd_q[k][1:0];
                        dz_q[k]    <= 1'b1;
                        exact_q[k] <= 1'b0;
                    end else begin
                        q_q[k]     <= quo_nxt[k];
                        r_q[k]     <= rem_nxt[k];
                        dz_q[k]    <= 1'b0;
                        exact_q[k] <= (rem_nxt[k] == 2'd0);
                    end
                end
            end
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.exact     = exact_q;
    assign bus.dz        = dz_q;

    for (genvar k = 0; k < LANES; k++) begin : g_planes
        assign bus.q3[k] = q_q[k][3];
        assign bus.q2[k] = q_q[k][2];
        assign bus.q1[k] = q_q[k][1];
        assign bus.q0[k] = q_q[k][0];
        assign bus.r1[k] = r_q[k][1];
        assign bus.r0[k] = r_q[k][0];
    end

endmodule

// File: tb/tb_mul4_vector_divider.sv
// Directed bench for mul4_vector_divider: hand-computed plane constants plus an
// integer-division reference for per-lane results.
module tb_mul4_vector_divider;
    localparam int LANES = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mul4_vector_divider_if #(.LANES(LANES)) bus ();

    mul4_vector_divider #(.LANES(LANES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [3:0] op_d [LANES];
    logic [1:0] op_v [LANES];
    logic [LANES-1:0] e_q3, e_q2, e_q1, e_q0, e_r1, e_r0, e_ex, e_dz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, zero divisor forces q=F, r=D[1:0].
    task automatic compute_expected();
        for (int k = 0; k < LANES; k++) begin
            int d, v, q, r;
            d = int'(op_d[k]);
            v = int'(op_v[k]);
            if (v == 0) begin
                q = 15; r = d % 4;
            end else begin
                q = d / v; r = d % v;
            end
            e_q3[k] = q[3]; e_q2[k] = q[2]; e_q1[k] = q[1]; e_q0[k] = q[0];
            e_r1[k] = r[1]; e_r0[k] = r[0];
            e_dz[k] = (v == 0);
            e_ex[k] = (v != 0) && (r == 0);
        end
    endtask

    task automatic drive_operands();
        for (int k = 0; k < LANES; k++) begin
            bus.y3[k] = op_d[k][3]; bus.y2[k] = op_d[k][2];
            bus.y1[k] = op_d[k][1]; bus.y0[k] = op_d[k][0];
            bus.b1[k] = op_v[k][1]; bus.b0[k] = op_v[k][0];
        end
    endtask

    task automatic check_planes(input string tag);
        check({tag, ".q3"},    32'(bus.q3),    32'(e_q3));
        check({tag, ".q2"},    32'(bus.q2),    32'(e_q2));
        check({tag, ".q1"},    32'(bus.q1),    32'(e_q1));
        check({tag, ".q0"},    32'(bus.q0),    32'(e_q0));
        check({tag, ".r1"},    32'(bus.r1),    32'(e_r1));
        check({tag, ".r0"},    32'(bus.r0),    32'(e_r0));
        check({tag, ".exact"}, 32'(bus.exact), 32'(e_ex));
        check({tag, ".dz"},    32'(bus.dz),    32'(e_dz));
    endtask

    // Accept on the next edge, then count edges until out_valid (bounded).
    task automatic run_op(input string tag);
        int n;
        compute_expected();
        drive_operands();
        bus.in_valid = 1'b1;
        check({tag, ".in_ready_pre"}, 32'(bus.in_ready), 32'd1);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check({tag, ".busy_in_ready"}, 32'(bus.in_ready), 32'd0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, ".latency"}, 32'(n), 32'd4);
        check_planes(tag);
    endtask

    task automatic finish_op(input string tag);
        @(posedge clk); #1;
        check({tag, ".post_out_valid"}, 32'(bus.out_valid), 32'd0);
        check({tag, ".post_in_ready"},  32'(bus.in_ready),  32'd1);
    endtask

    task automatic set_uniform(input logic [3:0] d, input logic [1:0] v);
        for (int k = 0; k < LANES; k++) begin
            op_d[k] = d; op_v[k] = v;
        end
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        set_uniform(4'd0, 2'd1);
        drive_operands();
        #12;
        check("reset.in_ready",  32'(bus.in_ready),  32'd1);
        check("reset.out_valid", 32'(bus.out_valid), 32'd0);
        check("reset.q1",        32'(bus.q1),        32'd0);
        check("reset.dz",        32'(bus.dz),        32'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Uniform 7/3 -> q=2, r=1.
        set_uniform(4'd7, 2'd3);
        run_op("uni73");
        check("uni73.hand_q1",    32'(bus.q1),    32'h0000FFFF);
        check("uni73.hand_q0",    32'(bus.q0),    32'h00000000);
        check("uni73.hand_r0",    32'(bus.r0),    32'h0000FFFF);
        check("uni73.hand_exact", 32'(bus.exact), 32'h00000000);
        finish_op("uni73");

        // Mixed lanes.
        set_uniform(4'd0, 2'd1);
        op_d[0] = 4'd15; op_v[0] = 2'd1;
        op_d[1] = 4'd9;  op_v[1] = 2'd3;
        op_d[2] = 4'd6;  op_v[2] = 2'd2;
        op_d[3] = 4'd5;  op_v[3] = 2'd2;
        run_op("mixed");
        check("mixed.hand_q3",    32'(bus.q3),    32'h00000001);
        check("mixed.hand_q1",    32'(bus.q1),    32'h0000000F);
        check("mixed.hand_q0",    32'(bus.q0),    32'h00000007);
        check("mixed.hand_r0",    32'(bus.r0),    32'h00000008);
        check("mixed.hand_exact", 32'(bus.exact), 32'h0000FFF7);
        finish_op("mixed");

        // Divide by zero on lanes 4 and 5; other lanes 7/3.
        set_uniform(4'd7, 2'd3);
        op_d[4] = 4'd13; op_v[4] = 2'd0;
        op_d[5] = 4'd2;  op_v[5] = 2'd0;
        run_op("dz");
        check("dz.hand_dz",    32'(bus.dz),    32'h00000030);
        check("dz.hand_q3",    32'(bus.q3),    32'h00000030);
        check("dz.hand_q1",    32'(bus.q1),    32'h0000FFFF);
        check("dz.hand_r1",    32'(bus.r1),    32'h00000020);
        check("dz.hand_r0",    32'(bus.r0),    32'h0000FFDF);
        check("dz.hand_exact", 32'(bus.exact), 32'h00000000);
        finish_op("dz");

        // Backpressure: hold results for 5 cycles while new operands are offered.
        bus.out_ready = 1'b0;
        set_uniform(4'd7, 2'd3);
        run_op("bp");
        set_uniform(4'd15, 2'd1);
        drive_operands();
        bus.in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp.hold_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp.hold_in_ready",  32'(bus.in_ready),  32'd0);
            check_planes("bp.hold");
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        finish_op("bp");
        @(posedge clk); #1;
        check("bp.no_spurious_op", 32'(bus.in_ready), 32'd1);

        // Reset two edges after accept, asynchronously between edges.
        set_uniform(4'd9, 2'd2);
        drive_operands();
        bus.in_valid = 1'b1;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("rstmid.out_valid", 32'(bus.out_valid), 32'd0);
        check("rstmid.in_ready",  32'(bus.in_ready),  32'd1);
        check("rstmid.q1",        32'(bus.q1),        32'd0);
        check("rstmid.r0",        32'(bus.r0),        32'd0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstmid.idle_after", 32'(bus.in_ready), 32'd1);
        set_uniform(4'd7, 2'd3);
        run_op("rstmid.uni73");
        finish_op("rstmid.uni73");

        // Exhaustive: operation j uses divisor j, lane k uses dividend k.
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < LANES; k++) begin
                op_d[k] = 4'(k);
                op_v[k] = 2'(j);
            end
            run_op($sformatf("exh.div%0d", j));
            finish_op($sformatf("exh.div%0d", j));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
